encode_loader: RTL and testbench

ENCODE_LOADER -- requirements
Module: encode_loader

---
 rtl/encode_loader.sv | 168 ++++++++++++++++
 tb/tb_encode_loader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encode_loader.sv
// encode_loader: packs RV32I instruction field tuples into 32-bit words, queues them in a small
// FIFO and streams them into an instruction memory at consecutive word addresses.
//
// Ports
//   clk        : clock, all state on rising edge
//   reset      : asynchronous active-high reset
//   clr        : synchronous flush of FIFO, address counter and flags
//   in_valid   : field tuple valid
//   in_ready   : tuple accepted when in_valid && in_ready
//   fmt        : 0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal (accepted, dropped, err pulse)
//   opcode, rd, funct3, rs1, rs2, funct7, imm : instruction fields
//   mem_we, mem_addr, mem_wdata : memory write port, held stable while mem_ready is low
//   mem_ready  : memory accepts the write this cycle
//   err        : one-cycle pulse after an illegal fmt was accepted
//   wrap       : sticky, set by the write to the last address
//   count      : words written since clr/reset, saturating at 2^ADDR_W
module encode_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              err,
  output logic              wrap,
  output logic [ADDR_W:0]   count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW:0]   FillFull = (PtrW + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CountMax = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    FmtR = 3'd0,
    FmtI = 3'd1,
    FmtS = 3'd2,
    FmtB = 3'd3,
    FmtU = 3'd4,
    FmtJ = 3'd5
  } fmt_e;

  // Encoder
  logic [31:0] enc_word;
  logic        enc_legal;

  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    case (fmt)
      FmtR:    enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      FmtI:    enc_word = {imm[11:0], rs1, funct3, rd, opcode};
      FmtS:    enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FmtB:    enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FmtU:    enc_word = {imm[31:12], rd, opcode};
      FmtJ:    enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: enc_legal = 1'b0;
    endcase
  end

  // FIFO state
  logic [31:0]     fifo_mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   fill_q, fill_d;

  // Memory-side state
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              wrap_q, wrap_d;
  logic              err_q, err_d;

  logic full, empty, accept, push, pop;

  assign full   = (fill_q == FillFull);
  assign empty  = (fill_q == '0);
  assign in_ready = !full && !clr;
  assign accept = in_valid && in_ready;
  assign push   = accept && enc_legal;
  // The head word only becomes visible after it is registered, so an empty FIFO never bypasses.
  assign pop    = !empty && mem_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    addr_d   = addr_q;
    count_d  = count_q;
    wrap_d   = wrap_q;
    err_d    = 1'b0;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
      addr_d   = '0;
      count_d  = '0;
      wrap_d   = 1'b0;
    end else begin
      err_d = accept && !enc_legal;
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        addr_d   = addr_q + 1'b1;
        if (&addr_q) begin
          wrap_d = 1'b1;
        end
        if (count_q != CountMax) begin
          count_d = count_q + 1'b1;
        end
      end
      case ({push, pop})
        2'b10:   fill_d = fill_q + 1'b1;
        2'b01:   fill_d = fill_q - 1'b1;
        default: fill_d = fill_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      addr_q   <= '0;
      count_q  <= '0;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      wrap_q   <= wrap_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: validity is tracked entirely by the pointers and fill level.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      fifo_mem[wr_ptr_q] <= enc_word;
    end
  end

  assign mem_we    = !empty;
  assign mem_wdata = fifo_mem[rd_ptr_q];
  assign mem_addr  = addr_q;
  assign count     = count_q;
  assign wrap      = wrap_q;
  assign err       = err_q;

endmodule

// File: tb/tb_encode_loader.sv
module tb_encode_loader;
  localparam int AW = 2;
  localparam int DP = 4;
  localparam int Lim = 1 << AW;

  logic          clk = 1'b0;
  logic          reset, clr, in_valid, mem_ready;
  logic [2:0]    fmt, funct3;
  logic [6:0]    opcode, funct7;
  logic [4:0]    rd, rs1, rs2;
  logic [31:0]   imm;
  logic          in_ready, mem_we, err, wrap;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;

  encode_loader #(.ADDR_W(AW), .DEPTH(DP)) dut (
    .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .err(err), .wrap(wrap), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] mq[$];
  int          maddr, mcount;
  bit          mwrap, merr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Builds the RV32I word by shifting and masking each field into place.
  function automatic logic [31:0] model_enc(input int f, input int op, input int d, input int f3,
                                            input int s1, input int s2, input int f7,
                                            input logic [31:0] i);
    logic [31:0] w;
    w = 32'(op & 127);
    if (f == 0 || f == 1 || f == 4 || f == 5) w |= 32'(d & 31) << 7;
    if (f <= 3) w |= (32'(f3 & 7) << 12) | (32'(s1 & 31) << 15);
    if (f == 0 || f == 2 || f == 3) w |= 32'(s2 & 31) << 20;
    case (f)
      0: w |= 32'(f7 & 127) << 25;
      1: w |= (i & 32'hFFF) << 20;
      2: w |= (((i >> 5) & 32'h7F) << 25) | ((i & 32'h1F) << 7);
      3: w |= (((i >> 12) & 1) << 31) | (((i >> 5) & 32'h3F) << 25) |
              (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 1) << 7);
      4: w |= i & 32'hFFFFF000;
      5: w |= (((i >> 20) & 1) << 31) | (((i >> 1) & 32'h3FF) << 21) |
              (((i >> 11) & 1) << 20) | (((i >> 12) & 32'hFF) << 12);
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  task automatic model_clear();
    mq.delete();
    maddr = 0;
    mcount = 0;
    mwrap = 0;
    merr = 0;
  endtask

  // Compare all outputs against the model, then advance the model across the next rising edge.
  task automatic step();
    bit rdy;
    #1;
    if (reset) model_clear();
    rdy = (mq.size() < DP) && !clr;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("mem_we", 32'(mem_we), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("mem_wdata", mem_wdata, mq[0]);
      chk("mem_addr", 32'(mem_addr), 32'(maddr));
    end
    chk("err", 32'(err), 32'(merr));
    chk("wrap", 32'(wrap), 32'(mwrap));
    chk("count", 32'(count), 32'(mcount));
    if (!reset) begin
      if (clr) begin
        model_clear();
      end else begin
        if (mq.size() != 0 && mem_ready) begin
          void'(mq.pop_front());
          if (maddr == Lim - 1) mwrap = 1;
          maddr = (maddr + 1) % Lim;
          if (mcount < Lim) mcount++;
        end
        merr = in_valid && rdy && (fmt >= 6);
        if (in_valid && rdy && fmt < 6)
          mq.push_back(model_enc(fmt, opcode, rd, funct3, rs1, rs2, funct7, imm));
      end
    end
    @(negedge clk);
  endtask

  task automatic set_tuple(input int f, input int op, input int d, input int f3, input int s1,
                           input int s2, input int f7, input logic [31:0] i);
    in_valid = 1'b1;
    fmt = 3'(f);
    opcode = 7'(op);
    rd = 5'(d);
    funct3 = 3'(f3);
    rs1 = 5'(s1);
    rs2 = 5'(s2);
    funct7 = 7'(f7);
    imm = i;
  endtask

  task automatic do_clr();
    in_valid = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  logic [31:0] words[4];
  int exp_a[5] = '{0, 1, 2, 3, 0};
  int k;

  initial begin
    reset = 1'b1;
    clr = 1'b0;
    mem_ready = 1'b0;
    set_tuple(0, 0, 0, 0, 0, 0, 0, 32'h0);
    in_valid = 1'b0;
    model_clear();

    // Model pins against hand-encoded words
    chk("enc_add", model_enc(0, 'h33, 3, 0, 1, 2, 0, 0), 32'h002081B3);
    chk("enc_addi", model_enc(1, 'h13, 5, 0, 0, 0, 0, 32'hFFFFFFFF), 32'hFFF00293);
    chk("enc_beq", model_enc(3, 'h63, 0, 0, 1, 2, 0, 32'hFFFFFFFC), 32'hFE208EE3);

    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    #1 chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    step();

    // add x3,x1,x2
    mem_ready = 1'b1;
    set_tuple(0, 'h33, 3, 0, 1, 2, 0, 32'h0);
    step();
    in_valid = 1'b0;
    #1 chk("add_we", 32'(mem_we), 32'd1);
    chk("add_word", mem_wdata, 32'h002081B3);
    chk("add_addr", 32'(mem_addr), 32'd0);
    step();
    #1 chk("add_count", 32'(count), 32'd1);
    step();

    // addi then beq
    do_clr();
    set_tuple(1, 'h13, 5, 0, 0, 0, 0, 32'hFFFFFFFF);
    step();
    set_tuple(3, 'h63, 0, 0, 1, 2, 0, 32'hFFFFFFFC);
    #1 chk("addi_word", mem_wdata, 32'hFFF00293);
    chk("addi_addr", 32'(mem_addr), 32'd0);
    step();
    in_valid = 1'b0;
    #1 chk("beq_word", mem_wdata, 32'hFE208EE3);
    chk("beq_addr", 32'(mem_addr), 32'd1);
    step();
    step();

    // Stall: five tuples, only four fit
    do_clr();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_tuple(0, 'h33, i + 1, 0, 1, 2, 0, 32'h0);
      if (i < 4) words[i] = model_enc(0, 'h33, i + 1, 0, 1, 2, 0, 32'h0);
      if (i == 4) #1 chk("stall_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    in_valid = 1'b0;
    #1 chk("stall_hold", mem_wdata, words[0]);
    step();
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("drain_addr", 32'(mem_addr), 32'(i));
      chk("drain_word", mem_wdata, words[i]);
      step();
    end
    step();

    // Illegal fmt between two legal tuples
    do_clr();
    set_tuple(2, 'h23, 0, 2, 3, 4, 0, 32'h10);
    step();
    set_tuple(7, 'h33, 1, 1, 1, 1, 1, 32'h0);
    step();
    set_tuple(4, 'h37, 9, 0, 0, 0, 0, 32'h12345000);
    #1 chk("err_pulse", 32'(err), 32'd1);
    step();
    in_valid = 1'b0;
    #1 chk("err_clear", 32'(err), 32'd0);
    step();
    step();
    step();
    #1 chk("err_writes", 32'(count), 32'd2);
    step();

    // Address wrap and count saturation
    do_clr();
    k = 0;
    for (int c = 0; c < 10; c++) begin
      if (c < 5) set_tuple(5, 'h6F, c, 0, 0, 0, 0, 32'(c * 8));
      else in_valid = 1'b0;
      #1;
      if (mem_we && k < 5) begin
        chk("wrap_addr", 32'(mem_addr), 32'(exp_a[k]));
        if (k == 3) chk("wrap_before", 32'(wrap), 32'd0);
        k++;
      end
      step();
    end
    #1 chk("wrap_writes", 32'(k), 32'd5);
    chk("wrap_set", 32'(wrap), 32'd1);
    chk("count_sat", 32'(count), 32'd4);
    step();

    // Reset in the middle of a stall
    do_clr();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_tuple(1, 'h13, i, 0, 1, 0, 0, 32'(i));
      step();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    #1 chk("rst_mid_we", 32'(mem_we), 32'd0);
    step();
    mem_ready = 1'b1;
    step();
    reset = 1'b0;
    step();
    #1 chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_addr", 32'(mem_addr), 32'd0);
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    step();

    // Randomised traffic
    for (int c = 0; c < 4000; c++) begin
      int bias;
      bias = (c / 500) % 3;
      in_valid = ($urandom_range(0, 9) < 7);
      fmt = 3'($urandom_range(0, 7));
      opcode = 7'($urandom);
      rd = 5'($urandom);
      funct3 = 3'($urandom);
      rs1 = 5'($urandom);
      rs2 = 5'($urandom);
      funct7 = 7'($urandom);
      imm = $urandom;
      mem_ready = (bias == 0) ? ($urandom_range(0, 9) < 2) :
                  (bias == 1) ? ($urandom_range(0, 9) < 5) : ($urandom_range(0, 9) < 9);
      clr = ($urandom_range(0, 59) == 0);
      reset = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0;
    clr = 1'b0;
    in_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
